// File: rtl/ddr3_pkg.sv
// Shared DDR3 command-port definitions: widths, arbiter state encoding and the
// burst-size normalisation used by both clients.
package ddr3_pkg;

  localparam int DDR3_ADDR_W = 26;
  localparam int DDR3_DATA_W = 128;
  localparam int DDR3_SIZE_W = 3;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD   = 2'd1,
    ARB_WR   = 2'd2
  } arb_state_e;

  // A zero burst size from a client means a single beat.
  function automatic logic [DDR3_SIZE_W-1:0] eff_size(input logic [DDR3_SIZE_W-1:0] s);
    return (s == '0) ? DDR3_SIZE_W'(1) : s;
  endfunction

endpackage

// File: rtl/ddr3_rd_credit.sv
// Tracks read beats requested but not yet returned and decides whether a new
// read burst still fits in the downstream read-data FIFO.
module ddr3_rd_credit
  import ddr3_pkg::*;
#(
  parameter int MAX_RD_OUTSTANDING = 256,
  parameter int OUTST_W            = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  input  logic [DDR3_SIZE_W-1:0] req_size,
  input  logic                   add_en,
  input  logic [DDR3_SIZE_W-1:0] add_size,
  input  logic                   ret,
  output logic [OUTST_W-1:0]     outstanding,
  output logic                   rd_ok
);

  logic [OUTST_W-1:0] cnt_q, cnt_d;
  logic [OUTST_W:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + (OUTST_W+1)'(req_size);
    rd_ok = req_valid && (sum <= (OUTST_W+1)'(MAX_RD_OUTSTANDING));
    cnt_d = cnt_q;
    // add_size is never 0, so accept-plus-return cannot underflow.
    if (add_en) begin
      cnt_d = cnt_q + OUTST_W'(add_size) - OUTST_W'(ret);
    end else if (ret && (cnt_q != '0)) begin
      cnt_d = cnt_q - OUTST_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign outstanding = cnt_q;

endmodule

// File: rtl/ddr3_avl_arbiter.sv
// Registered, burst-aware arbiter sharing the DDR3 Avalon-MM command port
// between a read client and a write client with bounded read priority.
module ddr3_avl_arbiter
  import ddr3_pkg::*;
#(
  parameter int RD_MAX_CONSEC      = 4,
  parameter int MAX_RD_OUTSTANDING = 256,
  parameter int OUTST_W            = 9
) (
  input  logic                   ddr3_clk,
  input  logic                   ddr3_reset_n,
  input  logic                   rd_req,
  input  logic [DDR3_ADDR_W-1:0] rd_addr,
  input  logic [DDR3_SIZE_W-1:0] rd_size,
  output logic                   rd_ready,
  input  logic                   wr_req,
  input  logic [DDR3_ADDR_W-1:0] wr_addr,
  input  logic [DDR3_SIZE_W-1:0] wr_size,
  input  logic [DDR3_DATA_W-1:0] wr_data,
  output logic                   wr_ready,
  input  logic                   ddr3_avl_ready,
  output logic                   ddr3_avl_burstbegin,
  output logic [DDR3_SIZE_W-1:0] ddr3_avl_size,
  output logic [DDR3_ADDR_W-1:0] ddr3_avl_addr,
  output logic                   ddr3_avl_read_req,
  output logic                   ddr3_avl_write_req,
  output logic [DDR3_DATA_W-1:0] ddr3_avl_wr_data,
  input  logic                   ddr3_avl_read_data_valid,
  output logic [OUTST_W-1:0]     rd_outstanding,
  output logic [1:0]             arb_state
);

  // Handshake: a client command/beat is consumed in exactly the cycle its
  // ready output is high; that ready is the controller's ready gated by the
  // arbiter being in the matching state.

  localparam int                  CONSEC_W   = $clog2(RD_MAX_CONSEC + 1);
  localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(RD_MAX_CONSEC);

  arb_state_e             state_q, state_d;
  logic [CONSEC_W-1:0]    consec_q, consec_d;
  logic [DDR3_SIZE_W-1:0] beat_q, beat_d;
  logic [DDR3_SIZE_W-1:0] size_q, size_d;
  logic [DDR3_ADDR_W-1:0] addr_q, addr_d;
  logic                   first_q, first_d;

  logic [DDR3_SIZE_W-1:0] eff_rd, eff_wr;
  logic                   rd_ok, rd_accept, wr_accept;

  assign eff_rd = eff_size(rd_size);
  assign eff_wr = eff_size(wr_size);

  ddr3_rd_credit #(
    .MAX_RD_OUTSTANDING (MAX_RD_OUTSTANDING),
    .OUTST_W            (OUTST_W)
  ) u_rd_credit (
    .clk         (ddr3_clk),
    .rst_n       (ddr3_reset_n),
    .req_valid   (rd_req),
    .req_size    (eff_rd),
    .add_en      (rd_accept),
    .add_size    (size_q),
    .ret         (ddr3_avl_read_data_valid),
    .outstanding (rd_outstanding),
    .rd_ok       (rd_ok)
  );

  always_comb begin
    state_d   = state_q;
    consec_d  = consec_q;
    beat_d    = beat_q;
    size_d    = size_q;
    addr_d    = addr_q;
    first_d   = 1'b0;
    rd_accept = (state_q == ARB_RD) && ddr3_avl_ready;
    wr_accept = (state_q == ARB_WR) && ddr3_avl_ready;
    case (state_q)
      ARB_IDLE: begin
        // A pending write wins once reads have had their run or cannot go.
        if (wr_req && ((consec_q >= CONSEC_MAX) || !rd_ok)) begin
          state_d  = ARB_WR;
          addr_d   = wr_addr;
          size_d   = eff_wr;
          consec_d = '0;
          first_d  = 1'b1;
        end else if (rd_ok) begin
          state_d  = ARB_RD;
          addr_d   = rd_addr;
          size_d   = eff_rd;
          first_d  = 1'b1;
          if (!wr_req) begin
            consec_d = '0;
          end else if (consec_q < CONSEC_MAX) begin
            consec_d = consec_q + CONSEC_W'(1);
          end
        end
      end
      ARB_RD: begin
        if (ddr3_avl_ready) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_WR: begin
        if (ddr3_avl_ready) begin
          if (beat_q == size_q - DDR3_SIZE_W'(1)) begin
            beat_d  = '0;
            state_d = ARB_IDLE;
          end else begin
            beat_d = beat_q + DDR3_SIZE_W'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      state_q  <= ARB_IDLE;
      consec_q <= '0;
      beat_q   <= '0;
      size_q   <= '0;
      addr_q   <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      consec_q <= consec_d;
      beat_q   <= beat_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      first_q  <= first_d;
    end
  end

  assign ddr3_avl_read_req   = (state_q == ARB_RD);
  assign ddr3_avl_write_req  = (state_q == ARB_WR);
  assign ddr3_avl_burstbegin = first_q;
  assign ddr3_avl_size       = size_q;
  assign ddr3_avl_addr       = addr_q;
  assign ddr3_avl_wr_data    = (state_q == ARB_WR) ? wr_data : '0;
  assign rd_ready            = rd_accept;
  assign wr_ready            = wr_accept;
  assign arb_state           = state_q;

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Scoreboard bench for ddr3_avl_arbiter: directed scenarios plus randomized
// two-client traffic checked against a transaction-level reference.
module tb_ddr3_avl_arbiter;
  import ddr3_pkg::*;

  localparam int RD_MAX  = 4;
  localparam int MAX_OUT = 16;
  localparam int OW      = 9;
  localparam int TMO     = 2000;
  localparam int RD_EW   = DDR3_ADDR_W + DDR3_SIZE_W;
  localparam int WR_EW   = DDR3_ADDR_W + DDR3_DATA_W;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   rd_req = 1'b0, wr_req = 1'b0;
  logic [DDR3_ADDR_W-1:0] rd_addr = '0, wr_addr = '0;
  logic [DDR3_SIZE_W-1:0] rd_size = '0, wr_size = '0;
  logic [DDR3_DATA_W-1:0] wr_data = '0;
  logic                   ddr3_avl_ready = 1'b0;
  logic                   ddr3_avl_read_data_valid = 1'b0;
  logic                   rd_ready, wr_ready, burstbegin, read_req, write_req;
  logic [DDR3_SIZE_W-1:0] avl_size;
  logic [DDR3_ADDR_W-1:0] avl_addr;
  logic [DDR3_DATA_W-1:0] avl_wr_data;
  logic [OW-1:0]          rd_outstanding;
  logic [1:0]             arb_state;

  logic [RD_EW-1:0] rd_exp_q[$];
  logic [WR_EW-1:0] wr_exp_q[$];
  byte              grant_log[$];
  int  tests = 0;
  int  fails = 0;
  int  model_outst = 0;
  int  consec_seen = 0;
  bit  prev_busy = 1'b0;
  bit  wr_req_prev = 1'b0;
  bit  bg_run = 1'b0;

  ddr3_avl_arbiter #(
    .RD_MAX_CONSEC      (RD_MAX),
    .MAX_RD_OUTSTANDING (MAX_OUT),
    .OUTST_W            (OW)
  ) dut (
    .ddr3_clk                 (clk),
    .ddr3_reset_n             (rst_n),
    .rd_req                   (rd_req),
    .rd_addr                  (rd_addr),
    .rd_size                  (rd_size),
    .rd_ready                 (rd_ready),
    .wr_req                   (wr_req),
    .wr_addr                  (wr_addr),
    .wr_size                  (wr_size),
    .wr_data                  (wr_data),
    .wr_ready                 (wr_ready),
    .ddr3_avl_ready           (ddr3_avl_ready),
    .ddr3_avl_burstbegin      (burstbegin),
    .ddr3_avl_size            (avl_size),
    .ddr3_avl_addr            (avl_addr),
    .ddr3_avl_read_req        (read_req),
    .ddr3_avl_write_req       (write_req),
    .ddr3_avl_wr_data         (avl_wr_data),
    .ddr3_avl_read_data_valid (ddr3_avl_read_data_valid),
    .rd_outstanding           (rd_outstanding),
    .arb_state                (arb_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DDR3_SIZE_W-1:0] norm(input logic [DDR3_SIZE_W-1:0] s);
    return (s == 3'd0) ? 3'd1 : s;
  endfunction

  // Monitor: compares every accepted command/beat and the credit count
  always @(negedge clk) begin
    logic [RD_EW-1:0] re;
    logic [WR_EW-1:0] we;
    int               add;
    if (!rst_n) begin
      model_outst = 0;
      prev_busy   = 1'b0;
      wr_req_prev = 1'b0;
      consec_seen = 0;
      rd_exp_q.delete();
      wr_exp_q.delete();
    end else begin
      add = 0;
      chk("rd_outstanding", 192'(rd_outstanding), 192'(model_outst));
      if (read_req || write_req) chk("one_cmd", 192'(read_req && write_req), 192'(0));
      if (burstbegin) begin
        chk("idle_gap", 192'(prev_busy), 192'(0));
        grant_log.push_back(read_req ? 8'd82 : 8'd87);
        if (read_req && wr_req_prev) begin
          consec_seen++;
          chk("rd_starve_bound", 192'(consec_seen <= RD_MAX), 192'(1));
        end else begin
          consec_seen = 0;
        end
      end
      if (read_req && ddr3_avl_ready) begin
        if (rd_exp_q.size() == 0) begin
          chk("rd_unexpected", 192'(rd_exp_q.size()), 192'(1));
        end else begin
          re  = rd_exp_q.pop_front();
          add = int'(re[DDR3_SIZE_W-1:0]);
          chk("rd_cmd", 192'({avl_addr, avl_size}), 192'(re));
        end
      end
      if (write_req && ddr3_avl_ready) begin
        if (wr_exp_q.size() == 0) begin
          chk("wr_unexpected", 192'(wr_exp_q.size()), 192'(1));
        end else begin
          we = wr_exp_q.pop_front();
          chk("wr_beat", 192'({avl_addr, avl_wr_data}), 192'(we));
        end
      end
      if (write_req) chk("wr_hold", 192'(wr_req), 192'(1));
      model_outst += add;
      if (ddr3_avl_read_data_valid && model_outst > 0) model_outst--;
      prev_busy   = read_req || write_req;
      wr_req_prev = wr_req;
    end
  end

  // Driver tasks
  task automatic read_client(input logic [DDR3_ADDR_W-1:0] a, input logic [DDR3_SIZE_W-1:0] s);
    int n = 0;
    rd_addr = a;
    rd_size = s;
    rd_req  = 1'b1;
    rd_exp_q.push_back({a, norm(s)});
    do begin
      @(negedge clk);
      n++;
    end while (!rd_ready && n < TMO);
    chk("rd_accept", 192'(rd_ready), 192'(1));
    tick();
    rd_req = 1'b0;
  endtask

  task automatic write_client(input logic [DDR3_ADDR_W-1:0] a, input logic [DDR3_SIZE_W-1:0] s);
    logic [DDR3_DATA_W-1:0] d[8];
    int beats = int'(norm(s));
    int n;
    for (int b = 0; b < beats; b++) begin
      d[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
      wr_exp_q.push_back({a, d[b]});
    end
    wr_addr = a;
    wr_size = s;
    wr_req  = 1'b1;
    for (int b = 0; b < beats; b++) begin
      wr_data = d[b];
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!wr_ready && n < TMO);
      chk("wr_accept", 192'(wr_ready), 192'(1));
      tick();
    end
    wr_req = 1'b0;
  endtask

  task automatic bg_traffic(input bit rnd);
    while (bg_run) begin
      tick();
      ddr3_avl_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      ddr3_avl_read_data_valid = (model_outst > 0) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
    end
    ddr3_avl_read_data_valid = 1'b0;
    ddr3_avl_ready = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (model_outst > 0 && n < 300) begin
      ddr3_avl_read_data_valid = 1'b1;
      tick();
      n++;
    end
    ddr3_avl_read_data_valid = 1'b0;
    tick();
  endtask

  initial begin
    int  pat[6] = '{1, 0, 0, 1, 1, 1};
    byte exp_seq[10] = '{8'd82, 8'd82, 8'd82, 8'd82, 8'd87, 8'd82, 8'd82, 8'd82, 8'd82, 8'd87};
    int  wr_cyc, bb_cnt, wrr_cnt;

    // Reset state
    @(negedge clk);
    chk("reset_ctrl", 192'({rd_ready, wr_ready, burstbegin, avl_size, avl_addr, read_req,
                            write_req, rd_outstanding, arb_state}), 192'(0));
    chk("reset_wdata", 192'(avl_wr_data), 192'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single read, ready held high
    ddr3_avl_ready = 1'b1;
    rd_addr = 26'h100; rd_size = 3'd4; rd_req = 1'b1;
    rd_exp_q.push_back({26'h100, 3'd4});
    @(negedge clk);
    chk("t1_idle_before", 192'(arb_state), 192'(ARB_IDLE));
    @(negedge clk);
    chk("t1_cmd", 192'({read_req, burstbegin, avl_addr, avl_size, rd_ready}),
        192'({1'b1, 1'b1, 26'h100, 3'd4, 1'b1}));
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    chk("t1_idle_after", 192'(arb_state), 192'(ARB_IDLE));
    chk("t1_outstanding", 192'(rd_outstanding), 192'(4));
    tick();
    drain();

    // Write burst with ready stalled after the first beat
    wr_cyc = 0; bb_cnt = 0; wrr_cnt = 0;
    fork
      write_client(26'h2000, 3'd4);
      begin
        for (int k = 0; k < 6; k++) begin
          tick();
          ddr3_avl_ready = pat[k][0];
        end
      end
      begin
        repeat (10) begin
          @(negedge clk);
          if (write_req) wr_cyc++;
          if (burstbegin) bb_cnt++;
          if (wr_ready) wrr_cnt++;
        end
      end
    join
    chk("t2_wr_cycles", 192'(wr_cyc), 192'(6));
    chk("t2_burstbegin", 192'(bb_cnt), 192'(1));
    chk("t2_wr_ready", 192'(wrr_cnt), 192'(4));
    tick();
    ddr3_avl_ready = 1'b1;

    // Both clients saturating: bounded read priority
    grant_log.delete();
    bg_run = 1'b1;
    fork
      begin
        fork
          for (int i = 0; i < 8; i++) read_client(26'($urandom()), 3'd1);
          for (int i = 0; i < 2; i++) write_client(26'($urandom()), 3'd1);
        join
        bg_run = 1'b0;
      end
      bg_traffic(1'b0);
    join
    chk("t3_grant_count", 192'(grant_log.size()), 192'(10));
    for (int i = 0; i < 10 && i < grant_log.size(); i++) begin
      chk("t3_grant_order", 192'(grant_log[i]), 192'(exp_seq[i]));
    end
    drain();

    // Credit limit blocks the fifth size-4 read
    ddr3_avl_ready = 1'b1;
    for (int i = 0; i < 4; i++) read_client(26'h4000 + 26'(i * 4), 3'd4);
    fork
      read_client(26'h5000, 3'd4);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("t4_stalled", 192'(arb_state), 192'(ARB_IDLE));
        end
        tick(); ddr3_avl_read_data_valid = 1'b1;
        tick(); tick();
        tick(); ddr3_avl_read_data_valid = 1'b0;
        @(negedge clk);
        chk("t4_three_ret", 192'({arb_state, rd_outstanding}), 192'({ARB_IDLE, 9'd13}));
        tick(); ddr3_avl_read_data_valid = 1'b1;
        tick(); ddr3_avl_read_data_valid = 1'b0;
        @(negedge clk);
        chk("t4_four_ret", 192'({arb_state, rd_outstanding}), 192'({ARB_IDLE, 9'd12}));
        @(negedge clk);
        chk("t4_granted", 192'({read_req, arb_state}), 192'({1'b1, ARB_RD}));
      end
    join
    drain();

    // Asynchronous reset during the second write beat
    read_client(26'h300, 3'd4);
    wr_exp_q.push_back({26'h600, 128'hD0});
    wr_addr = 26'h600; wr_size = 3'd4; wr_data = 128'hD0; wr_req = 1'b1;
    tick();
    tick();
    wr_data = 128'hD1;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_reset_drop", 192'({write_req, burstbegin, wr_ready, arb_state, rd_outstanding}), 192'(0));
    wr_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    ddr3_avl_read_data_valid = 1'b1;
    repeat (3) tick();
    ddr3_avl_read_data_valid = 1'b0;
    @(negedge clk);
    chk("t5_post_ret", 192'({arb_state, rd_outstanding}), 192'(0));
    tick();

    // Zero sizes normalise to one beat
    read_client(26'h700, 3'd0);
    @(negedge clk);
    chk("t6_rd_size0", 192'(rd_outstanding), 192'(1));
    tick();
    drain();
    wrr_cnt = 0;
    fork
      write_client(26'h800, 3'd0);
      begin
        repeat (6) begin
          @(negedge clk);
          if (wr_ready) wrr_cnt++;
        end
      end
    join
    chk("t6_wr_size0", 192'(wrr_cnt), 192'(1));
    tick();

    // Randomized two-client traffic
    bg_run = 1'b1;
    fork
      begin
        fork
          for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            read_client(26'($urandom()), 3'($urandom_range(0, 7)));
          end
          for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            write_client(26'($urandom()), 3'($urandom_range(0, 7)));
          end
        join
        bg_run = 1'b0;
      end
      bg_traffic(1'b1);
    join
    drain();
    @(negedge clk);
    chk("end_rd_queue", 192'(rd_exp_q.size()), 192'(0));
    chk("end_wr_queue", 192'(wr_exp_q.size()), 192'(0));
    chk("end_idle", 192'({arb_state, rd_outstanding}), 192'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ddr3_avl_arbiter.md
Name: ddr3_avl_arbiter

Overview:
Shares the single DDR3 Avalon-MM command port between a read client (video refill) and a write client (frame/test writer). It replaces the combinational read-priority mux with a registered, burst-aware arbiter. Read priority is bounded by an anti-starvation limit, and the read credit limit prevents the downstream read-data async FIFO from overflowing. The block sits in the ddr3_clk domain between the read/write engines and the DDR3 controller.

Parameters:
RD_MAX_CONSEC, 4, consecutive read grants allowed while a write is pending before a write is forced
MAX_RD_OUTSTANDING, 256, maximum read beats requested but not yet returned
OUTST_W, 9, width of the outstanding-beat counter; must hold MAX_RD_OUTSTANDING+7

Ports:
ddr3_clk  in  1  clock
ddr3_reset_n  in  1  asynchronous active-low reset
rd_req  in  1  read client command request, held until rd_ready
rd_addr  in  26  read word address
rd_size  in  3  read burst length in beats (0 treated as 1)
rd_ready  out  1  read command accepted this cycle
wr_req  in  1  write client request, held until the last beat is accepted
wr_addr  in  26  write start address
wr_size  in  3  write burst length (0 treated as 1)
wr_data  in  128  current write beat data
wr_ready  out  1  current write beat accepted this cycle
ddr3_avl_ready  in  1  controller ready
ddr3_avl_burstbegin  out  1  first cycle of a command
ddr3_avl_size  out  3  latched burst size
ddr3_avl_addr  out  26  latched address
ddr3_avl_read_req  out  1  read command
ddr3_avl_write_req  out  1  write beat
ddr3_avl_wr_data  out  128  wr_data forwarded
ddr3_avl_read_data_valid  in  1  read beat returned
rd_outstanding  out  OUTST_W  beats in flight
arb_state  out  2  0=IDLE 1=RD 2=WR

Behaviour:
- Reset: all outputs 0. State IDLE. Counters consec_rd, beat_cnt and rd_outstanding are 0.
- Arbitration happens in IDLE only. The decision is registered, so the Avalon command appears 1 cycle after the request is seen.
  - rd_ok = rd_req && (rd_outstanding + eff_rd_size <= MAX_RD_OUTSTANDING).
  - If wr_req && (consec_rd >= RD_MAX_CONSEC || !rd_ok), go to WR. Else if rd_ok, go to RD. Else if wr_req, go to WR. Else stay in IDLE.
  - On entering the chosen state, latch addr and eff size (size 0 becomes 1).
- consec_rd:
  - Increments, saturating at RD_MAX_CONSEC, on each RD grant.
  - Clears on a WR grant.
  - Clears on an RD grant when wr_req is low.
- RD state:
  - read_req=1 and size/addr are latched values.
  - burstbegin=1 only in the first RD cycle.
  - When ddr3_avl_ready: rd_ready=1 for that cycle, rd_outstanding += size, next state IDLE.
- WR state:
  - write_req=1 and wr_data is forwarded combinationally.
  - burstbegin=1 only in the first WR cycle, even if ready is low then.
  - Each cycle with ddr3_avl_ready: wr_ready=1 and beat_cnt++.
  - When the accepted beat is beat size-1: clear beat_cnt, next state IDLE.
  - wr_req dropping mid-burst is a client protocol error. The arbiter still finishes the burst count (assertion in the bench).
- Only one of read_req/write_req is ever high. Both are 0 in IDLE.
- One IDLE cycle always separates grants. This guarantees a client's still-high req in its completion cycle is never regranted.
- rd_outstanding:
  - Decrements by 1 per ddr3_avl_read_data_valid.
  - A simultaneous accept and return nets to +size-1.
  - Saturates at 0, since returns can arrive after reset for reads issued pre-reset.
- Async reset mid-burst: outputs drop immediately and the state returns to IDLE. The client must restart its burst.

Decomposition:
- Shared package ddr3_pkg:
  - arb_state encodings (ARB_IDLE/ARB_RD/ARB_WR).
  - DDR3_ADDR_W=26, DDR3_DATA_W=128, DDR3_SIZE_W=3.
- One sub-module: ddr3_rd_credit (the rd_outstanding counter with add/decrement/saturate and the rd_ok compare).
- The FSM, consec_rd and beat_cnt stay in the top.

Test Plan:
- rd_req, addr 0x100, size 4, ready held 1 → cycle 1: read_req=1, burstbegin=1, addr 0x100, size 4, rd_ready=1. Cycle 2: IDLE. rd_outstanding=4.
- wr_req, size 4, data D0..D3, ready low for 2 cycles after beat 1 → 4 write beats D0..D3 in order, 6 cycles in WR, burstbegin on the first cycle only, wr_ready high exactly 4 times.
- rd_req and wr_req continuously high, size 1, RD_MAX_CONSEC=4, ready=1, reads returned promptly → grant sequence R,R,R,R,W repeating.
- MAX_RD_OUTSTANDING=16, four size-4 reads with no returns, wr_req low → 5th read stalls in IDLE. 3 returns keep it blocked; the 4th return lets it be granted the next cycle.
- Reset asserted during the 2nd write beat → write_req/burstbegin drop in the same cycle, arb_state=0, rd_outstanding=0. Returns arriving afterwards keep the counter at 0.
- rd_size=0 → ddr3_avl_size=1, rd_outstanding increments by 1. wr_size=0 → a single write beat.
